// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: instruction-sequencing FSM plus ALU decoder.
// Latency: control word registered from the next state; lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles.
// Backpressure: none; the FSM advances every clock, reset low idles it in FETCH with writes off.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    // Sequencer states; encodings 12-15 are never produced by next_state.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // Opcodes the sequencer recognises.
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU function codes.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Per-state control word. funct_alu means alucontrol comes from the
    // funct decoder; funct_wb means regwrite is qualified by a legal funct.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       funct_alu;
        logic       funct_wb;
    } ctrl_t;

    // Successor of a state; opcode is consulted only in DECODE and MEMADR.
    function automatic state_t next_state(input state_t s, input logic [5:0] opc);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:   n = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_LW,
                    OP_SW:    n = S_MEMADR;
                    OP_RTYPE: n = S_RTYPEEX;
                    OP_BEQ:   n = S_BEQEX;
                    OP_ADDI:  n = S_ADDIEX;
                    OP_J:     n = S_JEX;
                    default:  n = S_FETCH;
                endcase
            end
            S_MEMADR:  n = (opc == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   n = S_MEMWB;
            S_MEMWB:   n = S_FETCH;
            S_MEMWR:   n = S_FETCH;
            S_RTYPEEX: n = S_RTYPEWB;
            S_RTYPEWB: n = S_FETCH;
            S_BEQEX:   n = S_FETCH;
            S_ADDIEX:  n = S_ADDIWB;
            S_ADDIWB:  n = S_FETCH;
            S_JEX:     n = S_FETCH;
            default:   n = S_FETCH;
        endcase
        return n;
    endfunction

    // Moore control word for a state; anything not named stays 0.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.iord       = 1'b0;
                c.alusrca    = 1'b0;
                c.alusrcb    = 2'b01;
                c.alucontrol = ALU_ADD;
                c.pcsrc      = 2'b00;
                c.irwrite    = 1'b1;
                c.pcwrite    = 1'b1;
            end
            S_DECODE: begin
                // Branch target PC + (imm << 2) is precomputed into ALUOut.
                c.alusrca    = 1'b0;
                c.alusrcb    = 2'b11;
                c.alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.regdst   = 1'b0;
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = 2'b00;
                c.funct_alu = 1'b1;
            end
            S_RTYPEWB: begin
                c.regdst   = 1'b1;
                c.memtoreg = 1'b0;
                c.regwrite = 1'b1;
                c.funct_wb = 1'b1;
            end
            S_BEQEX: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b00;
                c.alucontrol = ALU_SUB;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = ALU_ADD;
            end
            S_ADDIWB: begin
                c.regdst   = 1'b0;
                c.memtoreg = 1'b0;
                c.regwrite = 1'b1;
            end
            S_JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t cur_q;
    ctrl_t  cw_q;
    ctrl_t  cw_fetch;
    ctrl_t  cw;
    logic [2:0] rtype_alu;
    logic       funct_legal;

    // State register and control word registered from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_q <= S_FETCH;
            cw_q  <= decode_state(S_FETCH);
        end else begin
            cur_q <= next_state(cur_q, op);
            cw_q  <= decode_state(next_state(cur_q, op));
        end
    end

    // R-type funct decode; the IR is stable through EX and WB so both reuse it.
    always_comb begin
        rtype_alu   = ALU_ADD;
        funct_legal = 1'b0;
        case (funct)
            6'b100000: begin rtype_alu = ALU_ADD; funct_legal = 1'b1; end
            6'b100010: begin rtype_alu = ALU_SUB; funct_legal = 1'b1; end
            6'b100100: begin rtype_alu = ALU_AND; funct_legal = 1'b1; end
            6'b100101: begin rtype_alu = ALU_OR;  funct_legal = 1'b1; end
            6'b101010: begin rtype_alu = ALU_SLT; funct_legal = 1'b1; end
            default:   begin rtype_alu = ALU_ADD; funct_legal = 1'b0; end
        endcase
    end

    // While reset is low the datapath sees FETCH selects with every write off,
    // regardless of what the register still holds this cycle.
    assign cw_fetch = decode_state(S_FETCH);
    assign cw       = reset ? cw_q : cw_fetch;

    assign pcen       = reset & (cw.pcwrite | (cw.branch & zero));
    assign irwrite    = reset & cw.irwrite;
    assign memwrite   = reset & cw.memwrite;
    assign regwrite   = reset & cw.regwrite & (~cw.funct_wb | funct_legal);
    assign iord       = cw.iord;
    assign regdst     = cw.regdst;
    assign memtoreg   = cw.memtoreg;
    assign alusrca    = cw.alusrca;
    assign alusrcb    = cw.alusrcb;
    assign pcsrc      = cw.pcsrc;
    assign alucontrol = cw.funct_alu ? rtype_alu : cw.alucontrol;
    assign state      = cur_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction table, random instruction stream
// against a per-opcode state-sequence model, and reset corner cases.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .state(state)
    );

    typedef struct packed {
        logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
    } ctl_t;

    ctl_t act;
    assign act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, pcsrc, alucontrol};

    localparam logic [5:0] LEGAL_F [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    localparam logic [2:0] LEGAL_A [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    localparam logic [5:0] OPS     [6] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};

    function automatic logic f_ok(logic [5:0] f);
        for (int i = 0; i < 5; i++) if (LEGAL_F[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] f_alu(logic [5:0] f);
        for (int i = 0; i < 5; i++) if (LEGAL_F[i] == f) return LEGAL_A[i];
        return 3'b010;
    endfunction

    // Expected outputs for a state number, straight from the per-state table.
    function automatic ctl_t model_ctl(int s, logic [5:0] f, logic z, logic rn);
        ctl_t c;
        c = '0;
        if (!rn) begin
            c.alusrcb = 2'b01; c.alucontrol = 3'b010;
            return c;
        end
        case (s)
            0:  begin c.alusrcb = 2'b01; c.alucontrol = 3'b010; c.irwrite = 1; c.pcen = 1; end
            1:  begin c.alusrcb = 2'b11; c.alucontrol = 3'b010; end
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
            3:  begin c.iord = 1; end
            4:  begin c.memtoreg = 1; c.regwrite = 1; end
            5:  begin c.iord = 1; c.memwrite = 1; end
            6:  begin c.alusrca = 1; c.alucontrol = f_alu(f); end
            7:  begin c.regdst = 1; c.regwrite = f_ok(f); end
            8:  begin c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
            9:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
            10: begin c.regwrite = 1; end
            11: begin c.pcsrc = 2'b10; c.pcen = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // State walk for a whole instruction, FETCH through its final state.
    task automatic build_seq(input logic [5:0] o, output int q[$]);
        case (o)
            6'h23:   q = {0, 1, 2, 3, 4};
            6'h2b:   q = {0, 1, 2, 5};
            6'h00:   q = {0, 1, 6, 7};
            6'h04:   q = {0, 1, 8};
            6'h08:   q = {0, 1, 9, 10};
            6'h02:   q = {0, 1, 11};
            default: q = {0, 1};
        endcase
    endtask

    task automatic check_state(input string name, input int exp);
        total++;
        if (state !== exp[3:0]) begin
            bad++;
            $display("FAIL %s state: got %0d want %0d", name, state, exp);
        end
    endtask

    task automatic check_ctl(input string name, input ctl_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s ctl (state %0d): got %h want %h", name, state, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Run one instruction from FETCH, checking state and outputs every cycle.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f);
        int q[$];
        build_seq(o, q);
        op = o;
        funct = f;
        foreach (q[i]) begin
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_state(tag, q[i]);
            check_ctl(tag, model_ctl(q[i], f, zero, 1'b1));
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        logic [2:0] alu;      // alucontrol in the third cycle (or last, if shorter)
        logic       pcen;     // pcen in that same cycle
        logic       regw;     // regwrite in the final cycle
    } vec_t;

    vec_t vt [13];

    initial begin
        int n;
        logic done;
        logic [2:0] alu_c;
        logic pcen_c, rw_c;
        logic [5:0] ro, rf;

        vt[0]  = '{6'h23, 6'h00, 1'b0, 5, 3'b010, 1'b0, 1'b1};
        vt[1]  = '{6'h2b, 6'h00, 1'b0, 4, 3'b010, 1'b0, 1'b0};
        vt[2]  = '{6'h00, 6'h2a, 1'b0, 4, 3'b111, 1'b0, 1'b1};
        vt[3]  = '{6'h00, 6'h20, 1'b0, 4, 3'b010, 1'b0, 1'b1};
        vt[4]  = '{6'h00, 6'h22, 1'b0, 4, 3'b110, 1'b0, 1'b1};
        vt[5]  = '{6'h00, 6'h24, 1'b0, 4, 3'b000, 1'b0, 1'b1};
        vt[6]  = '{6'h00, 6'h25, 1'b0, 4, 3'b001, 1'b0, 1'b1};
        vt[7]  = '{6'h00, 6'h00, 1'b0, 4, 3'b010, 1'b0, 1'b0};
        vt[8]  = '{6'h04, 6'h00, 1'b1, 3, 3'b110, 1'b1, 1'b0};
        vt[9]  = '{6'h04, 6'h00, 1'b0, 3, 3'b110, 1'b0, 1'b0};
        vt[10] = '{6'h08, 6'h00, 1'b0, 4, 3'b010, 1'b0, 1'b1};
        vt[11] = '{6'h02, 6'h00, 1'b0, 3, 3'b000, 1'b1, 1'b0};
        vt[12] = '{6'h3f, 6'h00, 1'b0, 2, 3'b010, 1'b0, 1'b0};

        // Power-up reset held for 3 edges.
        reset = 1'b0;
        op = 6'h2b;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_state("reset_hold", 0);
            check_ctl("reset_hold", model_ctl(0, 6'h00, 1'b0, 1'b0));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_ctl("post_release", model_ctl(0, 6'h00, 1'b0, 1'b1));
        @(posedge clk); #1;
        check_state("first_fetch", 1);
        @(posedge clk); #1;   // DECODE -> MEMADR
        @(posedge clk); #1;   // MEMADR -> MEMWR
        @(posedge clk); #1;   // MEMWR -> FETCH
        check_state("sw_return", 0);

        // Instruction table: cycle count, exec-cycle ALU/pcen, final regwrite.
        for (int v = 0; v < 13; v++) begin
            op = vt[v].op;
            funct = vt[v].funct;
            zero = vt[v].zero;
            n = 0;
            done = 1'b0;
            alu_c = 3'b000;
            pcen_c = 1'b0;
            rw_c = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (n <= 2) begin
                    alu_c = alucontrol;
                    pcen_c = pcen;
                end
                rw_c = regwrite;
                @(posedge clk); #1;
                n++;
                if (state == 4'd0 || n >= 10) done = 1'b1;
            end
            check_val($sformatf("vec%0d cycles", v), n, vt[v].cycles);
            check_val($sformatf("vec%0d alucontrol", v), int'(alu_c), int'(vt[v].alu));
            check_val($sformatf("vec%0d pcen", v), int'(pcen_c), int'(vt[v].pcen));
            check_val($sformatf("vec%0d regwrite", v), int'(rw_c), int'(vt[v].regw));
        end

        // Random instruction stream against the sequence model.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) < 8) ro = OPS[$urandom_range(0, 5)];
            else ro = 6'($urandom);
            if ($urandom_range(0, 1) == 0) rf = LEGAL_F[$urandom_range(0, 4)];
            else rf = 6'($urandom);
            run_instr($sformatf("rand%0d op%h f%h", k, ro, rf), ro, rf);
        end

        // Reset in the middle of lw (in MEMRD), held 3 cycles.
        op = 6'h23;
        repeat (3) begin @(posedge clk); #1; end
        check_state("lw_mid", 3);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_ctl("lw_reset", model_ctl(0, 6'h00, 1'b0, 1'b0));
            @(posedge clk); #1;
            check_state("lw_reset", 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_state("lw_restart", 1);
        repeat (4) begin @(posedge clk); #1; end
        check_state("lw_restart_done", 0);

        // Reset while in MEMWR: the store must not happen.
        op = 6'h2b;
        repeat (3) begin @(posedge clk); #1; end
        check_state("sw_mid", 5);
        @(negedge clk);
        check_val("sw_memwrite_normal", int'(memwrite), 1);
        @(posedge clk); #1;
        check_state("sw_done", 0);
        repeat (3) begin @(posedge clk); #1; end
        check_state("sw_mid2", 5);
        reset = 1'b0;
        @(negedge clk);
        check_val("sw_reset_memwrite", int'(memwrite), 0);
        check_ctl("sw_reset", model_ctl(0, 6'h00, 1'b0, 1'b0));
        @(posedge clk); #1;
        check_state("sw_reset_next", 0);
        reset = 1'b1;

        // Reset while in RTYPEWB with a legal funct: the register write is dropped.
        op = 6'h00;
        funct = 6'h20;
        repeat (3) begin @(posedge clk); #1; end
        check_state("r_mid", 7);
        reset = 1'b0;
        @(negedge clk);
        check_val("r_reset_regwrite", int'(regwrite), 0);
        @(posedge clk); #1;
        check_state("r_reset_next", 0);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
